// File: rtl/sar_defs_pkg.sv
// sar_defs: shared state encoding and legal comparator codes for the SAR search controller.
package sar_defs;
  typedef enum logic [1:0] {IDLE = 2'd0, TEST = 2'd1, DONE = 2'd2} state_t;
  localparam logic [2:0] CMP_EQ = 3'b100;
  localparam logic [2:0] CMP_GT = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;
endpackage

// File: rtl/sar_cmp_decode.sv
// sar_cmp_decode: classifies one comparator decision into take/eq/invalid.
module sar_cmp_decode
  import sar_defs::*;
(
  input  logic cmp_aeb,
  input  logic cmp_agb,
  input  logic cmp_alb,
  output logic take,
  output logic eq,
  output logic invalid
);
  logic [2:0] code;
  assign code    = {cmp_aeb, cmp_agb, cmp_alb};
  assign take    = cmp_agb | cmp_aeb;
  assign eq      = cmp_aeb;
  assign invalid = (code != CMP_EQ) && (code != CMP_GT) && (code != CMP_LT);
endmodule

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: successive-approximation search driving a comparator b operand.
// Define SAR_EARLY_EXIT_EN to finish as soon as the comparator reports equality.
module sar_search_ctrl
  import sar_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic [WIDTH-1:0]               trial,
  input  logic                           cmp_aeb,
  input  logic                           cmp_agb,
  input  logic                           cmp_alb,
  output logic                           busy,
  output logic                           done,
  output logic [WIDTH-1:0]               result,
  output logic [$clog2(WIDTH+1)-1:0]     ncmp,
  output logic                           err
);
  localparam int IW = $clog2(WIDTH);
  localparam int NW = $clog2(WIDTH+1);
`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif
  state_t         state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [NW-1:0]  ncmp_q, ncmp_d;
  logic           err_q, err_d;
  logic           take, eq, invalid, early;
  sar_cmp_decode u_dec (
    .cmp_aeb (cmp_aeb),
    .cmp_agb (cmp_agb),
    .cmp_alb (cmp_alb),
    .take    (take),
    .eq      (eq),
    .invalid (invalid)
  );
  assign early  = EARLY_EXIT & eq & ~invalid;
  assign busy   = state_q == TEST;
  assign done   = state_q == DONE;
  assign result = acc_q;
  assign ncmp   = ncmp_q;
  assign err    = err_q;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    ncmp_d  = ncmp_q;
    err_d   = err_q;
    trial   = busy ? (acc_q | (WIDTH'(1) << idx_q)) : acc_q;
    if (state_q == IDLE && start) begin
      state_d = TEST;
      acc_d   = '0;
      idx_d   = IW'(WIDTH-1);
      ncmp_d  = '0;
      err_d   = 1'b0;
    end else if (state_q == TEST) begin
      ncmp_d  = ncmp_q + 1'b1;
      acc_d   = (take && !invalid) ? trial : acc_q;
      err_d   = err_q | invalid;
      state_d = (idx_q == '0 || early) ? DONE : TEST;
      idx_d   = (idx_q == '0) ? idx_q : idx_q - 1'b1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      ncmp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      ncmp_q  <= ncmp_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl: scoreboard bench with a behavioural comparator against a target register.
module tb_sar_search_ctrl;
  logic       clk = 0, rst = 1, start = 0;
  logic [3:0] target = 0, trial, result;
  logic [2:0] ncmp, code, force_code = 0;
  logic       busy, done, err, force_en = 0;
  always #5 clk = ~clk;
  always_comb code = force_en ? force_code :
                     (target == trial) ? 3'b100 : (target > trial) ? 3'b010 : 3'b001;
  sar_search_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .trial(trial),
    .cmp_aeb(code[2]), .cmp_agb(code[1]), .cmp_alb(code[0]),
    .busy(busy), .done(done), .result(result), .ncmp(ncmp), .err(err)
  );
`ifdef SAR_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  typedef struct {logic [3:0] res; int n; logic e; int lat;} exp_t;
  exp_t       exp_q[$];
  logic [3:0] tq[$];
  int pass_cnt = 0, total = 0, cyc = 0, start_cyc = 0;
  logic busy_prev = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s: got %0d want %0d", name, act, expv);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (busy && !busy_prev) start_cyc = cyc;
      if (busy) begin
        if (tq.size() == 0) chk("trial_unexpected", 1, 0);
        else chk("trial", trial, tq.pop_front());
      end
      if (done) begin
        if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("result", result, e.res);
          chk("done_trial", trial, e.res);
          chk("ncmp", ncmp, e.n);
          chk("err", err, e.e);
          chk("latency", cyc - start_cyc + 1, e.lat);
        end
      end
    end
    busy_prev = busy;
  end
  task automatic expect_search(input logic [15:0] tr, input int nt, input logic [3:0] res, input logic e);
    logic [15:0] t;
    t = tr;
    for (int i = 0; i < nt; i++) tq.push_back(t[15-4*i -: 4]);
    exp_q.push_back('{res, nt, e, nt + 1});
  endtask
  task automatic wait_drain();
    for (int i = 0; i < 30 && (exp_q.size() != 0 || tq.size() != 0); i++) @(posedge clk);
    if (exp_q.size() != 0 || tq.size() != 0) begin
      chk("timeout", 1, 0);
      exp_q.delete();
      tq.delete();
    end
    @(posedge clk) #2;
  endtask
  task automatic go(input logic [3:0] tgt, input logic [15:0] tr, input int nt, input logic [3:0] res, input logic e);
    expect_search(tr, nt, res, e);
    @(posedge clk) #2;
    target = tgt;
    start  = 1;
    @(posedge clk) #2;
    start  = 0;
    wait_drain();
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_trial", trial, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ncmp", ncmp, 0);
    chk("rst_err", err, 0);
    rst = 0;
    go(11, 16'h8CAB, 4, 11, 0);
    if (EE) go(8, 16'h8000, 1, 8, 0);
    else    go(8, 16'h8CA9, 4, 8, 0);
    go(0, 16'h8421, 4, 0, 0);
    go(15, 16'h8CEF, 4, 15, 0);
    // start held from launch through DONE: second search starts in the IDLE cycle
    expect_search(16'h8CA9, 4, 9, 0);
    expect_search(16'h8423, 4, 3, 0);
    @(posedge clk) #2;
    target = 9;
    start  = 1;
    repeat (6) @(posedge clk);
    #2;
    target = 3;
    chk("idle_gap_busy", busy, 0);
    chk("idle_gap_done", done, 0);
    @(posedge clk) #2;
    chk("relaunch_busy", busy, 1);
    start = 0;
    wait_drain();
    // reset during the second TEST cycle
    tq.push_back(4'd8);
    @(posedge clk) #2;
    target = 11;
    start  = 1;
    @(posedge clk) #2;
    start = 0;
    @(posedge clk) #2;
    rst = 1;
    @(posedge clk) #2;
    chk("abort_trial", trial, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_tq_empty", tq.size(), 0);
    tq.delete();
    rst = 0;
    go(5, 16'h8465, 4, 5, 0);
    force_en   = 1;
    force_code = 3'b000;
    go(7, 16'h8421, 4, 0, 1);
    force_en = 0;
    expect_search(16'h8465, 4, 5, 0);
    @(posedge clk) #2;
    target = 5;
    start  = 1;
    @(posedge clk) #2;
    start = 0;
    chk("err_cleared", err, 0);
    wait_drain();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/sar_search_ctrl.md
# sar_search_ctrl

Sequential successive-approximation controller that drives the `b` operand of a magnitude comparator and consumes its `aeb`/`agb`/`alb` outputs. It binary-searches for an unknown `a` operand (the target), one comparator decision per clock. The result is a WIDTH-bit value equal to the target. It sits on the opposite side of the comparator interface: the comparator reports the relation, and this block turns a sequence of relations into a number.

## Interface
- `WIDTH`, default 4: operand width. Legal values are 2 to 16.
- `clk`: input, 1 bit. Sole clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Reset, synchronous and active-high.
- `start`: input, 1 bit. Begins a search; sampled only in IDLE.
- `trial`: output, WIDTH bits. Value driven to the comparator `b` input.
- `cmp_aeb`: input, 1 bit. Comparator reports target == trial.
- `cmp_agb`: input, 1 bit. Comparator reports target > trial.
- `cmp_alb`: input, 1 bit. Comparator reports target < trial.
- `busy`: output, 1 bit. High while in TEST.
- `done`: output, 1 bit. One-cycle pulse in DONE.
- `result`: output, WIDTH bits. Search result; valid from `done` until the next accepted `start`.
- `ncmp`: output, clog2(WIDTH+1) bits. Number of TEST cycles used by the last search.
- `err`: output, 1 bit. Sticky; set if any sampled comparator code was not one-hot. Cleared on accepted `start`.

## Operation
- Registers:
  - `state`: IDLE, TEST or DONE.
  - `idx`: bit under test.
  - `acc`: committed bits.
  - `ncmp`, `err`.
- Reset values: state=IDLE, acc=0, idx=0, ncmp=0, err=0. Therefore trial=0, result=0, busy=0, done=0.
- IDLE:
  - trial=acc, result=acc.
  - If `start`=1: acc←0, idx←WIDTH-1, ncmp←0, err←0, go to TEST.
- TEST: trial = acc | (1<<idx), combinationally from registers. On each edge:
  - ncmp←ncmp+1.
  - If cmp_agb|cmp_aeb: acc←trial.
  - Otherwise (cmp_alb, or an invalid code): acc is unchanged.
  - Invalid code is any {aeb,agb,alb} not in {100,010,001}. It sets err and is treated as alb.
  - If idx==0: go to DONE. Otherwise idx←idx-1.
- DONE: done=1, busy=0, trial=result=acc. Next edge goes to IDLE unconditionally.
- `start` is ignored in TEST and DONE. A `start` held high through DONE launches a new search in the IDLE cycle that follows.
- Comparator path is combinational. The comparator sees `trial` and answers within the same cycle; there is no wait state.
- `rst` mid-search: the next edge returns all registers to reset values and the in-flight search is discarded. No `done` pulse is produced.

## Timing
- Accepted `start` at edge 0 puts the block in TEST from edge 0 to edge WIDTH. `done` is high in the cycle after edge WIDTH.
- Latency from `start` sampled to `done` high is WIDTH+1 cycles.
- Back-to-back throughput is one search per WIDTH+2 cycles.
- `trial` changes only on clock edges and is glitch-free relative to registers.

## Configuration
- `SAR_EARLY_EXIT_EN` defined: in TEST, cmp_aeb=1 (a valid code) does acc←trial and goes to DONE immediately. The remaining low bits stay 0, which is correct because trial already equals the target. `ncmp` reports the reduced count. Minimum latency is 2 cycles.
- `SAR_EARLY_EXIT_EN` undefined: every search runs exactly WIDTH TEST cycles, and `ncmp` is always WIDTH.

## Structure
- Shared package/header `sar_defs`:
  - state encoding localparams: IDLE=2'd0, TEST=2'd1, DONE=2'd2;
  - legal comparator codes CMP_EQ=3'b100, CMP_GT=3'b010, CMP_LT=3'b001.
- One sub-module, `sar_cmp_decode`: takes the 3 comparator bits and outputs `take` (agb|aeb), `eq` and `invalid`.
- The FSM, `acc` and `idx` live in `sar_search_ctrl`.

## Test plan
Bench instantiates WIDTH=4 with a behavioural comparator against a target register.
- Target 11, early-exit off: trials 8,12,10,11; `result`=11, `ncmp`=4, `done` 5 cycles after start, err=0.
- Target 8:
  - early-exit on: trial 8 gives aeb; `done` 2 cycles after start, `result`=8, `ncmp`=1.
  - early-exit off: trials 8,12,10,9, `result`=8.
- Boundaries:
  - target 0: trials 8,4,2,1, all alb, `result`=0.
  - target 15: trials 8,12,14,15, `result`=15.
- `start` pulsed again during TEST and held through DONE: first search is unaffected, `result` correct; second search begins in the IDLE cycle after DONE.
- `rst` asserted on the 2nd TEST cycle: the next cycle has trial=0, busy=0, done=0, result=0. A subsequent start with target 5 yields 5.
- Comparator forced to 3'b000 for the whole search: `result`=0, err=1 at `done`. err clears on the next accepted start.
